// File: rtl/spu_sram_reader.sv
// Block reader for two single-port synchronous-read SRAMs. It streams a contiguous run of word pairs to the SPU.
// Optional cycle statistics are enabled with `define SPU_SRAM_READER_STATS_EN.
module spu_sram_reader #(
  parameter int DATA_BITS    = 64,
  parameter int ADDR_BITS    = 10,
  parameter int READ_LATENCY = 2,
  parameter int LEN_BITS     = ADDR_BITS + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cke,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr0,
  input  logic [ADDR_BITS-1:0] base_addr1,
  input  logic [LEN_BITS-1:0]  len,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_en,
  output logic [ADDR_BITS-1:0] mem0_addr,
  input  logic [DATA_BITS-1:0] mem0_rdata,
  output logic [ADDR_BITS-1:0] mem1_addr,
  input  logic [DATA_BITS-1:0] mem1_rdata,
  output logic [DATA_BITS-1:0] m_data0,
  output logic [DATA_BITS-1:0] m_data1,
  output logic                 m_valid
`ifdef SPU_SRAM_READER_STATS_EN
  ,
  output logic [31:0]          stat_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                  state, state_next;
  logic [LEN_BITS-1:0]     remaining;
  logic [READ_LATENCY-1:0] vpipe, vpipe_next;
  logic                    accept;
  logic                    issue;
  logic                    last_issue;

  assign mem_en     = cke;
  assign accept     = (state == IDLE) && start;
  assign issue      = (state == ISSUE);
  assign last_issue = issue && (remaining == LEN_BITS'(1));

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else if (cke) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: a default assignment first means no path through this block leaves state_next unassigned, so no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:  if (start) state_next = (len == '0) ? DONE : ISSUE;
      ISSUE: if (last_issue) state_next = DRAIN;
      DRAIN: if (vpipe == '0) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      ISSUE, DRAIN: busy = 1'b1;
      DONE:         done = 1'b1;
      default:      ;
    endcase
  end

  // Bit i of vpipe is set when the SRAM data for an issued address is i+1 enabled edges old.
  always_comb begin
    vpipe_next    = '0;
    vpipe_next[0] = issue;
    for (int i = 1; i < READ_LATENCY; i++) vpipe_next[i] = vpipe[i-1];
  end

  // The address advances after each issue except the last, so it holds the final address during drain.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem0_addr <= '0;
      mem1_addr <= '0;
      remaining <= '0;
      vpipe     <= '0;
      m_valid   <= 1'b0;
      m_data0   <= '0;
      m_data1   <= '0;
    end else if (cke) begin
      if (accept) begin
        remaining <= len;
        if (len != '0) begin
          mem0_addr <= base_addr0;
          mem1_addr <= base_addr1;
        end
      end else if (issue) begin
        remaining <= remaining - LEN_BITS'(1);
        if (!last_issue) begin
          mem0_addr <= mem0_addr + ADDR_BITS'(1);
          mem1_addr <= mem1_addr + ADDR_BITS'(1);
        end
      end
      vpipe   <= vpipe_next;
      m_valid <= vpipe[READ_LATENCY-1];
      if (vpipe[READ_LATENCY-1]) begin
        m_data0 <= mem0_rdata;
        m_data1 <= mem1_rdata;
      end
    end
  end

`ifdef SPU_SRAM_READER_STATS_EN
  logic [31:0] stat_count;

  // The counter runs on raw clock edges, so stalled cycles of a transfer are included.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_count  <= '0;
      stat_cycles <= '0;
    end else begin
      if (cke && accept) stat_count <= '0;
      else if (busy && stat_count != '1) stat_count <= stat_count + 32'd1;
      if (done) stat_cycles <= stat_count;
    end
  end
`endif

endmodule

// File: tb/tb_spu_sram_reader.sv
// Randomized scoreboard bench for spu_sram_reader.
// A transfer-level model predicts each word and its enabled-cycle time stamp. It also predicts the busy/done windows.
module tb_spu_sram_reader;
  localparam int DB = 64;
  localparam int AB = 10;
  localparam int RL = 2;
  localparam int LB = AB + 1;
  localparam int DEPTH = 1 << AB;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cke = 1'b0;
  logic          start = 1'b0;
  logic [AB-1:0] base_addr0 = '0;
  logic [AB-1:0] base_addr1 = '0;
  logic [LB-1:0] len = '0;
  logic          busy, done, mem_en, m_valid;
  logic [AB-1:0] mem0_addr, mem1_addr;
  logic [DB-1:0] mem0_rdata, mem1_rdata, m_data0, m_data1;

  spu_sram_reader #(.DATA_BITS(DB), .ADDR_BITS(AB), .READ_LATENCY(RL), .LEN_BITS(LB)) dut (
    .clk(clk), .reset_n(reset_n), .cke(cke), .start(start),
    .base_addr0(base_addr0), .base_addr1(base_addr1), .len(len),
    .busy(busy), .done(done), .mem_en(mem_en),
    .mem0_addr(mem0_addr), .mem0_rdata(mem0_rdata),
    .mem1_addr(mem1_addr), .mem1_rdata(mem1_rdata),
    .m_data0(m_data0), .m_data1(m_data1), .m_valid(m_valid)
  );

  always #5 clk = ~clk;

  // SRAM model: data appears RL enabled edges after the address is presented.
  logic [DB-1:0] mem0 [DEPTH];
  logic [DB-1:0] mem1 [DEPTH];
  logic [DB-1:0] p0 [RL];
  logic [DB-1:0] p1 [RL];

  always @(posedge clk) begin
    if (mem_en) begin
      for (int i = RL - 1; i > 0; i--) begin
        p0[i] <= p0[i-1];
        p1[i] <= p1[i-1];
      end
      p0[0] <= mem0[mem0_addr];
      p1[0] <= mem1[mem1_addr];
    end
  end
  assign mem0_rdata = p0[RL-1];
  assign mem1_rdata = p1[RL-1];

  // Enabled-cycle counter: all model time stamps are in these units.
  int ecyc = 0;
  always @(posedge clk) if (cke) ecyc <= ecyc + 1;

  typedef struct {int t; logic [DB-1:0] d0; logic [DB-1:0] d1;} word_t;
  typedef struct {int t; logic [AB-1:0] a0; logic [AB-1:0] a1;} addr_t;

  word_t wq[$];
  addr_t aq[$];
  int busy_lo = 1, busy_hi = 0, done_at = -10;
  int checks = 0, passes = 0;

  task automatic check(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (ecyc %0d)", name, act, exp, ecyc);
  endtask

  // Monitor: pops the scoreboard whenever the SPU would consume a word (m_valid with cke).
  always @(negedge clk) begin
    if (reset_n) begin
      check("busy", 64'(busy), 64'(ecyc >= busy_lo && ecyc <= busy_hi));
      check("done", 64'(done), 64'(ecyc == done_at));
      if (cke) begin
        if (aq.size() > 0 && aq[0].t == ecyc) begin
          addr_t a;
          a = aq.pop_front();
          check("mem0_addr", 64'(mem0_addr), 64'(a.a0));
          check("mem1_addr", 64'(mem1_addr), 64'(a.a1));
        end
        if (m_valid) begin
          if (wq.size() == 0) begin
            check("unexpected_valid", 64'(m_valid), 64'(0));
          end else begin
            word_t w;
            w = wq.pop_front();
            check("word_time", 64'(ecyc), 64'(w.t));
            check("m_data0", m_data0, w.d0);
            check("m_data1", m_data1, w.d1);
          end
        end else if (wq.size() > 0 && wq[0].t <= ecyc) begin
          void'(wq.pop_front());
          check("missing_valid", 64'(m_valid), 64'(1));
        end
      end
    end
  end

  function automatic logic pick_cke(input int mode, input int i);
    case (mode)
      0:       return 1'b1;
      1:       return (i % 2) == 1;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  task automatic step(input logic c);
    @(posedge clk);
    #1;
    start = 1'b0;
    cke   = c;
  endtask

  // Drive a start in an enabled cycle and record what the transfer must produce.
  task automatic issue_start(input logic [AB-1:0] b0, input logic [AB-1:0] b1, input int n);
    int s;
    @(posedge clk);
    #1;
    cke = 1'b1; start = 1'b1;
    base_addr0 = b0; base_addr1 = b1; len = LB'(n);
    s = ecyc;
    if (n == 0) begin
      busy_lo = 1; busy_hi = 0;
      done_at = s + 1;
    end else begin
      busy_lo = s + 1;
      busy_hi = s + RL + 1 + n;
      done_at = s + RL + 2 + n;
      for (int k = 0; k < n; k++) begin
        logic [AB-1:0] a0, a1;
        a0 = b0 + AB'(k);
        a1 = b1 + AB'(k);
        aq.push_back('{t: s + 1 + k, a0: a0, a1: a1});
        wq.push_back('{t: s + RL + 2 + k, d0: mem0[a0], d1: mem1[a1]});
      end
    end
  endtask

  task automatic run_until_done(input int mode, input int inject_at);
    int i;
    i = 0;
    while (ecyc <= done_at && i < 4000) begin
      step(pick_cke(mode, i));
      if (i == inject_at) begin
        start = 1'b1;
        len = LB'(8);
        base_addr0 = AB'($urandom);
        base_addr1 = AB'($urandom);
      end
      i++;
    end
    check("timeout", 64'(i < 4000), 64'(1));
    check("words_left", 64'(wq.size()), 64'(0));
    check("addrs_left", 64'(aq.size()), 64'(0));
  endtask

  task automatic xfer(input logic [AB-1:0] b0, input logic [AB-1:0] b1, input int n,
                      input int mode, input int inject_at);
    issue_start(b0, b1, n);
    run_until_done(mode, inject_at);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AB-1:0] prev0, prev1;
    for (int a = 0; a < DEPTH; a++) begin
      mem0[a] = {32'($urandom), 32'(a)};
      mem1[a] = {32'($urandom), 32'(32'h1000 + a)};
    end
    for (int i = 0; i < RL; i++) begin
      p0[i] = '0;
      p1[i] = '0;
    end

    // Reset with cke low must still clear everything.
    repeat (3) step(1'b0);
    #1;
    reset_n = 1'b1;
    cke = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_valid", 64'(m_valid), 64'(0));
    check("rst_data0", m_data0, 64'(0));
    check("rst_data1", m_data1, 64'(0));
    check("rst_addr0", 64'(mem0_addr), 64'(0));
    check("rst_addr1", 64'(mem1_addr), 64'(0));

    // Basic, stalled, zero-length, wrap and start-while-busy transfers.
    xfer(10'h010, 10'h020, 4, 0, -1);
    xfer(10'h010, 10'h020, 4, 1, -1);
    prev0 = mem0_addr;
    prev1 = mem1_addr;
    xfer(10'h100, 10'h200, 0, 0, -1);
    check("zero_addr0", 64'(mem0_addr), 64'(prev0));
    check("zero_addr1", 64'(mem1_addr), 64'(prev1));
    xfer(10'h3FE, 10'h3FF, 4, 0, -1);
    xfer(10'h040, 10'h050, 4, 0, 1);
    xfer(10'h060, 10'h070, 4, 2, 2);

    // Reset during ISSUE aborts the transfer without a done pulse.
    issue_start(10'h080, 10'h090, 16);
    repeat (3) step(1'b1);
    reset_n = 1'b0;
    wq.delete();
    aq.delete();
    busy_lo = 1; busy_hi = 0; done_at = -10;
    step(1'b1);
    reset_n = 1'b1;
    @(negedge clk);
    check("abort_valid", 64'(m_valid), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    repeat (8) step(1'b1);
    xfer(10'h0A0, 10'h0B0, 2, 0, -1);

    // Randomized transfers, plus one longer than the address space.
    for (int t = 0; t < 20; t++)
      xfer(AB'($urandom), AB'($urandom), $urandom_range(0, 40), 2, -1);
    xfer(10'h3F0, 10'h005, 1030, 0, 500);

    repeat (4) step(1'b1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/spu_sram_reader.md
Name: spu_sram_reader

Overview:
- Upstream feeder for the stream processing unit.
- On a start command, reads a contiguous block of words from two single-port synchronous-read SRAMs, one per source operand.
- Presents the words as a valid-qualified dual-operand stream (m_data0/m_data1/m_valid) that connects directly to the SPU's s_data0/s_data1/s_valid inputs.
- Shares the SPU's clock enable. No backpressure exists; cke is the only stall mechanism.

Parameters:
- DATA_BITS, 64: word width of each SRAM and of each output operand.
- ADDR_BITS, 10: SRAM address width.
- READ_LATENCY, 2: SRAM read latency in enabled cycles, from address to data. Legal range 1..4.
- LEN_BITS, ADDR_BITS+1: width of the transfer length field.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; synchronous, active-low.
- cke  in  1  clock enable. All state advances only when cke=1.
- start  in  1  start request, sampled when cke=1.
- base_addr0  in  ADDR_BITS  first address for SRAM0, sampled with start.
- base_addr1  in  ADDR_BITS  first address for SRAM1, sampled with start.
- len  in  LEN_BITS  number of words to read, sampled with start.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- mem_en  out  1  SRAM enable; mem_en = cke. It gates both the SRAM address register and the SRAM output register.
- mem0_addr  out  ADDR_BITS  SRAM0 read address.
- mem0_rdata  in  DATA_BITS  SRAM0 read data.
- mem1_addr  out  ADDR_BITS  SRAM1 read address.
- mem1_rdata  in  DATA_BITS  SRAM1 read data.
- m_data0  out  DATA_BITS  operand 0 stream.
- m_data1  out  DATA_BITS  operand 1 stream.
- m_valid  out  1  stream data valid.

Behaviour:
- Reset: when reset_n=0 at a clk edge, independent of cke:
  - FSM goes to IDLE and the issue pipeline is cleared.
  - busy, done, m_valid, m_data0, m_data1, mem0_addr, mem1_addr are all 0.
  - Reset mid-transfer aborts the transfer. No done pulse is generated.
- Stall: when cke=0, every register holds (FSM, counters, pipeline, outputs). done and m_valid hold their current value.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 with cke=1 latches the base addresses and len, then goes to ISSUE.
  - If len=0, go directly to DONE instead.
  - busy rises in the cycle after start is accepted.
- ISSUE:
  - Each enabled cycle drives mem0_addr = base0+k and mem1_addr = base1+k, with k = 0..len-1.
  - Each issue shifts a 1 into a READ_LATENCY-deep valid pipeline.
  - After the issue with k=len-1, go to DRAIN.
  - Addresses wrap modulo 2^ADDR_BITS. Example: 0x3FF+1 = 0x000.
- DRAIN:
  - Shifts 0s into the valid pipeline.
  - When the valid pipeline and the output register are both empty, go to DONE.
- DONE:
  - done=1 for exactly one enabled cycle, and busy=0 in that same cycle.
  - Then return to IDLE.
- Output stage (registered):
  - When the pipeline tail is 1, m_data0/m_data1 are loaded from mem0_rdata/mem1_rdata and m_valid=1; otherwise m_valid=0.
  - m_data holds its last value when m_valid=0.
- Latency: word k appears on m_valid READ_LATENCY+1 enabled cycles after its address is issued.
- Throughput: one word per enabled cycle, with no gaps between the words of a transfer.
- start while busy (states ISSUE, DRAIN, DONE): ignored. It is neither queued nor flagged.
- len greater than 2^ADDR_BITS is legal; the read simply wraps and rereads.

Optional Feature:
- Macro: SPU_SRAM_READER_STATS_EN.
- Defined:
  - Adds output port stat_cycles [31:0].
  - An internal counter clears on start acceptance and increments on every clk edge while busy=1, including cke=0 cycles. It saturates at 0xFFFFFFFF.
  - stat_cycles is loaded from the counter when done=1 and holds until the next done. Reset value 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Basic read: READ_LATENCY=2, cke=1, SRAM0[a]=a, SRAM1[a]=0x1000+a; start with base0=0x010, base1=0x020, len=4 -> m_valid high 4 consecutive cycles with m_data0=0x10..0x13 and m_data1=0x1020..0x1023. First valid 4 cycles after the start cycle. done pulses once, the cycle after the last valid; busy falls in that same cycle.
- Stall: same transfer, cke toggled 1,0,1,0,... -> identical data sequence with each word held during cke=0. done count=1, and no word is duplicated or dropped.
- Zero length: start with len=0 -> no m_valid, no address change; busy=0 throughout and done=1 exactly 1 cycle after start.
- Wrap: base0=0x3FE, base1=0x3FF, len=4 -> mem0_addr sequence 0x3FE,0x3FF,0x000,0x001 and mem1_addr sequence 0x3FF,0x000,0x001,0x002; data matches those addresses.
- start during busy: second start with len=8 issued mid-transfer of len=4 -> exactly 4 words output and one done; the second request is lost.
- Reset mid-transfer: reset_n=0 for 1 cycle during ISSUE of len=16 -> next cycle m_valid=0, busy=0, done=0. No further valid output. A new start afterwards with len=2 yields exactly 2 correct words.
